// File: rtl/wb_queue.sv
// Writeback queue feeding the register file write port.
// Orders load-before-ALU; a write to R15 becomes a PC redirect and flushes the queue.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  input  logic [3:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        ld_byte,
  input  logic [1:0]  ld_addr_lo,
  output logic        stall,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic [14:0] pend_mask
);

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t             q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [PTR_W:0]   npush;
  logic [31:0]      ld_sh;
  logic [31:0]      ld_wdata;
  logic             pop;
  logic             redir;
  logic             push_ld;
  logic             push_alu;
  logic [15:0]      mask16;
  ent_t             hd;

  assign hd = q[head];

  always_comb begin
    ld_sh    = ld_data >> {ld_addr_lo, 3'b000};
    ld_wdata = ld_byte ? {24'b0, ld_sh[7:0]} : ld_data;
  end

  assign pop      = (count != '0);
  assign redir    = pop && (hd.rd == 4'hF);
  assign push_ld  = ld_valid && !stall && !redir;
  assign push_alu = alu_valid && !stall && !redir;
  assign npush    = (PTR_W+1)'(push_ld) + (PTR_W+1)'(push_alu);

  always_comb begin
    count_next = count + npush - (PTR_W+1)'(pop);
    if (redir)
      count_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      stall <= 1'b0;
    end else begin
      count <= count_next;
      stall <= count_next > (PTR_W+1)'(DEPTH - 2);
      if (redir) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= head + PTR_W'(pop);
        tail <= tail + PTR_W'(npush);
      end
    end
  end

  // Load is the older instruction, so it takes the lower slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      if (push_ld)
        q[tail] <= '{rd: ld_rd, data: ld_wdata};
      if (push_alu)
        q[push_ld ? tail + PTR_W'(1) : tail] <=
          '{rd: alu_rd, data: alu_result};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else begin
      we3   <= pop && !redir;
      pc_we <= redir;
      if (pop && !redir) begin
        wa3 <= hd.rd;
        wd3 <= hd.data;
      end
      if (redir)
        pc_wd <= {hd.data[31:2], 2'b00};
    end
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    mask16 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head;
      if ({1'b0, off} < count && q[i].rd != 4'hF)
        mask16[q[i].rd] = 1'b1;
    end
  end

  assign pend_mask = mask16[14:0];

endmodule
